// File: rtl/pin_debounce_if.sv
// Pin-side bundle for the debouncer: raw pin levels in, debounced levels and
// per-bit change strobes out.
interface pin_debounce_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic [WIDTH-1:0] CHANGED;

  modport master (
    output I,
    input  O,
    input  CHANGED
  );

  modport slave (
    input  I,
    output O,
    output CHANGED
  );
endinterface

// File: rtl/pin_debounce.sv
// Per-bit two-flop synchronizer followed by a saturating debounce counter; a new
// level is accepted only after THRESHOLD consecutive cycles at the synchronizer.
module pin_debounce #(
  parameter int WIDTH     = 6,
  parameter int THRESHOLD = 65536
) (
  input  logic          CLK,
  input  logic          RESET,
  pin_debounce_if.slave bus
);

  localparam int CW = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(THRESHOLD - 1);

  logic [WIDTH-1:0] o_vec;
  logic [WIDTH-1:0] changed_vec;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic          s1_reg;
      logic          s2_reg;
      logic [CW-1:0] cnt_reg;
      logic          o_reg;
      logic          changed_reg;
      logic [CW-1:0] cnt_next;
      logic          o_next;
      logic          changed_next;

      // Counter only runs while the synchronized level disagrees with O; it
      // saturates at CNT_MAX, where the new level is accepted.
      always_comb begin
        cnt_next     = '0;
        o_next       = o_reg;
        changed_next = 1'b0;
        if (s2_reg != o_reg) begin
          if (cnt_reg == CNT_MAX) begin
            o_next       = s2_reg;
            changed_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          s1_reg      <= 1'b0;
          s2_reg      <= 1'b0;
          cnt_reg     <= '0;
          o_reg       <= 1'b0;
          changed_reg <= 1'b0;
        end else begin
          s1_reg      <= bus.I[gi];
          s2_reg      <= s1_reg;
          cnt_reg     <= cnt_next;
          o_reg       <= o_next;
          changed_reg <= changed_next;
        end
      end

      assign o_vec[gi]       = o_reg;
      assign changed_vec[gi] = changed_reg;
    end
  endgenerate

  assign bus.O       = o_vec;
  assign bus.CHANGED = changed_vec;

endmodule

// File: doc/pin_debounce.md
# pin_debounce

Input conditioner between the board header pins (J1) and the combinational logic stage that consumes them, e.g. the 3-input, 2-lane AND stage fed as I0=J1[1:0], I1=J1[3:2], I2=J1[5:4]. Each bit passes through a two-flop synchronizer, then a per-bit saturating debounce counter. A stable bit drives `O` only after it has held a new level for `THRESHOLD` consecutive cycles. A one-cycle `CHANGED` strobe marks every accepted transition.

## Interface
- `WIDTH`, default 6: number of independent input bits.
- `THRESHOLD`, default 65536: consecutive post-synchronizer cycles a new level must persist before it is accepted. Legal range is 1..2^24.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset. It is sampled on the `CLK` rising edge and has priority over all other behaviour.
- `I` input, `WIDTH` bits: raw asynchronous pin levels.
- `O` output, `WIDTH` bits: debounced stable levels, registered.
- `CHANGED` output, `WIDTH` bits: per-bit one-cycle pulse, high in the cycle after `O[n]` toggles, registered.

## Operation
- Per bit n there are four pieces of state:
  - `s1[n]`: first synchronizer flop, samples `I[n]`.
  - `s2[n]`: second synchronizer flop, samples `s1[n]`.
  - `cnt[n]`: counter, width max(1, clog2(`THRESHOLD`)).
  - `O[n]`: accepted level.
- Bits are fully independent. There is no cross-bit interaction.
- Each rising edge without reset:
  - If `s2[n] == O[n]`: `cnt[n]` <= 0, `O[n]` holds.
  - If `s2[n] != O[n]` and `cnt[n] < THRESHOLD-1`: `cnt[n]` <= `cnt[n]`+1, `O[n]` holds.
  - If `s2[n] != O[n]` and `cnt[n] == THRESHOLD-1`: `O[n]` <= `s2[n]`, `cnt[n]` <= 0.
  - `CHANGED[n]` <= 1 exactly on the edge where `O[n]` toggles, otherwise 0.
- Glitch rejection: a mismatch lasting fewer than `THRESHOLD` cycles at `s2` clears the counter on return. `O` does not move and `CHANGED` stays 0.
- The counter never exceeds `THRESHOLD-1`, so there is no wrap-around.
- Reset values: `s1`, `s2`, `cnt`, `O` and `CHANGED` are all 0.
- Reset asserted mid-count discards the partial count. After release, a pin held at 1 must requalify for a full `THRESHOLD` cycles plus synchronizer delay.
- Simultaneous transitions on several bits each complete independently and may strobe `CHANGED` in the same cycle.

## Timing
- Latency is measured from the first rising edge that samples the new `I[n]` into `s1`, counted as edge 1.
- `O[n]` updates on edge `THRESHOLD`+2. With `THRESHOLD`=1, it updates on edge 3.
- `CHANGED[n]` is high for exactly the one cycle following that edge, i.e. aligned with the first cycle `O[n]` shows the new value.
- Minimum spacing between two accepted toggles of one bit is `THRESHOLD` cycles.
- `O` and `CHANGED` are pure flop outputs, with no combinational path from `I`.
- Downstream combinational logic may sample `O` on any edge.

## Test plan
All scenarios use `THRESHOLD`=4, `WIDTH`=6.
- Reset: hold `RESET`=1 for 3 cycles with `I`=6'h3F. Required: `O`=0 and `CHANGED`=0 throughout. After release with `I` held at 6'h3F: `O`=6'h3F on edge 6 after release, `CHANGED`=6'h3F for that one cycle only.
- Clean step: drive `I` 6'h00 -> 6'h15 from stable 0. Required: `O`=6'h15 exactly on edge 6 and not before. `CHANGED`=6'h15 for one cycle, then 6'h00.
- Glitch rejection: pulse `I[2]` high for 3 cycles, then low. Required: `O` stays 6'h00 and `CHANGED` stays 0. A 4-cycle pulse instead produces `O[2]`=1 on edge 6, then `O[2]`=0 on edge 6 after `I[2]` falls.
- Bounce: toggle `I[0]` every cycle for 10 cycles, then hold at 1. Required: no `O[0]` change during bouncing. `O[0]`=1 on edge 6 after the final hold begins.
- Reset mid-count: raise `I[5]`, assert `RESET` on edge 4 for 1 cycle. Required: `O[5]`=0 with no `CHANGED` pulse. `O[5]` becomes 1 only on edge 6 after `RESET` deasserts.
- Independent bits: `I[1]` rises at cycle 0 and `I[4]` at cycle 2. Required: `CHANGED[1]` and `CHANGED[4]` pulse two cycles apart. Downstream, And3x2 lane 1 output (J1[1]&J1[3]&J1[5]) follows only after all three inputs qualify.
